// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Result is formed from captured operands and written only on the commit edge.
module mdu_hilo #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic signed [WIDTH-1:0]   sa;
    logic signed [WIDTH-1:0]   sb;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic                      div0;
    logic                      ovf;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_wr;

    assign busy = (state == RUN);

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q})
                  * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign sa     = $signed(a_q);
    assign sb     = $signed(b_q);
    assign quot_s = sa / sb;
    assign rem_s  = sa % sb;
    assign div0   = ~|b_q;
    // min-negative / -1 cannot be represented; pin the architectural result
    assign ovf    = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_wr = 1'b1;
        case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                if (div0) begin
                    res_wr = 1'b0;
                end else if (ovf) begin
                    res_hi = '0;
                    res_lo = a_q;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            default: begin
                if (div0) begin
                    res_wr = 1'b0;
                end else begin
                    res_hi = a_q % b_q;
                    res_lo = a_q / b_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        unique case (1'b1)
                            !op[2]: begin
                                state <= RUN;
                                op_q  <= op[1:0];
                                a_q   <= A;
                                b_q   <= B;
                                cnt   <= op[1] ? CW'(DIV_CYCLES)
                                               : CW'(MULT_CYCLES);
                            end
                            (op == 3'd4): hi <= A;
                            (op == 3'd5): lo <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= IDLE;
                            if (res_wr) begin
                                hi <= res_hi;
                                lo <= res_lo;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
